// File: rtl/spi_state_tx_if.sv
// rtl/spi_state_tx_if.sv - load handshake, SPI pins and status bundle for spi_state_tx
interface spi_state_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] i_Data;
    logic              i_Valid;
    logic              o_Ready;
    logic              i_SCK;
    logic              i_CS_n;
    logic              o_MISO;
    logic              o_MISO_En;
    logic              o_Done;
    logic              o_Underrun;
    logic              o_Abort;
    logic              o_Busy;

    modport master (
        output i_Data, i_Valid, i_SCK, i_CS_n,
        input  o_Ready, o_MISO, o_MISO_En, o_Done, o_Underrun, o_Abort, o_Busy
    );

    modport slave (
        input  i_Data, i_Valid, i_SCK, i_CS_n,
        output o_Ready, o_MISO, o_MISO_En, o_Done, o_Underrun, o_Abort, o_Busy
    );
endinterface

// File: rtl/spi_state_tx.sv
// rtl/spi_state_tx.sv - SPI mode-0 slave transmitter with one-deep holding register
module spi_state_tx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    spi_state_tx_if.slave bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic { IDLE, SHIFT } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_hist;
    logic                   cs_hist;
    logic [DATA_W-1:0]      hold_data;
    logic                   hold_full;
    logic [DATA_W-1:0]      shift;
    logic [CNT_W-1:0]       cnt;
    logic                   frame_seen;
    logic                   uflow_pend;
    logic                   done_p;
    logic                   underrun_p;
    logic                   abort_p;

    logic sck_s, cs_s;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_hist;
    assign sck_fall = ~sck_s & sck_hist;
    assign cs_fall  = ~cs_s & cs_hist;
    assign cs_rise  = cs_s & ~cs_hist;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            sck_sync <= '0;
            cs_sync  <= '1;
            sck_hist <= 1'b0;
            cs_hist  <= 1'b1;
        end else begin
            sck_sync[0] <= bus.i_SCK;
            cs_sync[0]  <= bus.i_CS_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_sync[i] <= sck_sync[i-1];
                cs_sync[i]  <= cs_sync[i-1];
            end
            sck_hist <= sck_s;
            cs_hist  <= cs_s;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            state      <= IDLE;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            shift      <= '0;
            cnt        <= '0;
            frame_seen <= 1'b0;
            uflow_pend <= 1'b0;
            done_p     <= 1'b0;
            underrun_p <= 1'b0;
            abort_p    <= 1'b0;
        end else begin
            done_p     <= 1'b0;
            underrun_p <= 1'b0;
            abort_p    <= 1'b0;

            // A write lands only while empty; a load only drains while full, so the
            // two never act on the register in the same cycle (no bypass).
            if (bus.i_Valid && !hold_full) begin
                hold_data <= bus.i_Data;
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state      <= SHIFT;
                        cnt        <= '0;
                        frame_seen <= 1'b0;
                        uflow_pend <= 1'b0;
                        if (hold_full) begin
                            shift     <= hold_data;
                            hold_full <= 1'b0;
                        end else begin
                            shift      <= '0;
                            underrun_p <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state      <= IDLE;
                        shift      <= '0;
                        cnt        <= '0;
                        uflow_pend <= 1'b0;
                        if (cnt != '0)
                            abort_p <= 1'b1;
                    end else begin
                        if (sck_rise) begin
                            if (cnt == LAST_BIT) begin
                                cnt        <= '0;
                                frame_seen <= 1'b1;
                                done_p     <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                            // An empty back-to-back reload only counts as an underrun
                            // once the master actually clocks into the new frame.
                            if (uflow_pend) begin
                                underrun_p <= 1'b1;
                                uflow_pend <= 1'b0;
                            end
                        end
                        if (sck_fall) begin
                            if (cnt == '0 && frame_seen) begin
                                if (hold_full) begin
                                    shift     <= hold_data;
                                    hold_full <= 1'b0;
                                end else begin
                                    shift      <= '0;
                                    uflow_pend <= 1'b1;
                                end
                            end else begin
                                shift <= shift << 1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_Ready    = ~hold_full;
    assign bus.o_Busy     = (state == SHIFT);
    assign bus.o_MISO_En  = (state == SHIFT);
    assign bus.o_MISO     = (state == SHIFT) & shift[DATA_W-1];
    assign bus.o_Done     = done_p;
    assign bus.o_Underrun = underrun_p;
    assign bus.o_Abort    = abort_p;
endmodule

// File: tb/tb_spi_state_tx.sv
// tb/tb_spi_state_tx.sv - directed vector bench for spi_state_tx
module tb_spi_state_tx;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   n_done;
    int   n_under;
    int   n_abort;

    spi_state_tx_if #(.DATA_W(8)) bus ();

    spi_state_tx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_Done)     n_done++;
        if (bus.o_Underrun) n_under++;
        if (bus.o_Abort)    n_abort++;
    end

    typedef struct {
        bit         do_wr;
        logic [7:0] wr;
        logic [7:0] exp;
        int         exp_under;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_done  = 0;
        n_under = 0;
        n_abort = 0;
    endtask

    task automatic write_byte(input logic [7:0] v);
        bus.i_Valid = 1'b1;
        bus.i_Data  = v;
        @(negedge clk);
        bus.i_Valid = 1'b0;
    endtask

    // Master clocks n bits, sampling MISO just before each rising edge.
    task automatic clock_bits(input int n, input int wr_bit, input logic [7:0] wr_val,
                              output logic [15:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            if (i == wr_bit) write_byte(wr_val);
            repeat (8) @(negedge clk);
            got = {got[14:0], bus.o_MISO};
            bus.i_SCK = 1'b1;
            repeat (8) @(negedge clk);
            bus.i_SCK = 1'b0;
        end
    endtask

    task automatic run_frame(input int n, input int wr_bit, input logic [7:0] wr_val,
                             output logic [15:0] got);
        bus.i_CS_n = 1'b0;
        repeat (4) @(negedge clk);
        check("miso_en_latency", {31'd0, bus.o_MISO_En}, 32'd1);
        repeat (4) @(negedge clk);
        clock_bits(n, wr_bit, wr_val, got);
        repeat (8) @(negedge clk);
        bus.i_CS_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [15:0] got;
        errors = 0;
        checks = 0;
        clear_counts();
        rst         = 1'b0;
        bus.i_CS_n  = 1'b1;
        bus.i_SCK   = 1'b0;
        bus.i_Valid = 1'b0;
        bus.i_Data  = '0;

        vecs[0] = '{1'b1, 8'h02, 8'h02, 0};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 1};
        vecs[2] = '{1'b1, 8'hA5, 8'hA5, 0};
        vecs[3] = '{1'b1, 8'hFF, 8'hFF, 0};
        vecs[4] = '{1'b1, 8'h80, 8'h80, 0};

        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, bus.o_Ready}, 32'd1);
        check("rst_outs", {26'd0, bus.o_MISO, bus.o_MISO_En, bus.o_Done,
                           bus.o_Underrun, bus.o_Abort, bus.o_Busy}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // SCK toggling with CS high must not start anything.
        clear_counts();
        for (int i = 0; i < 3; i++) begin
            bus.i_SCK = 1'b1;
            repeat (8) @(negedge clk);
            bus.i_SCK = 1'b0;
            repeat (8) @(negedge clk);
        end
        check("idle_sck_busy", {31'd0, bus.o_Busy}, 32'd0);
        check("idle_sck_done", n_done, 0);

        for (int v = 0; v < 5; v++) begin
            clear_counts();
            if (vecs[v].do_wr) begin
                write_byte(vecs[v].wr);
                check($sformatf("v%0d_ready_after_wr", v), {31'd0, bus.o_Ready}, 32'd0);
            end
            run_frame(8, -1, 8'h00, got);
            check($sformatf("v%0d_byte", v), {24'd0, got[7:0]}, {24'd0, vecs[v].exp});
            check($sformatf("v%0d_done", v), n_done, 1);
            check($sformatf("v%0d_under", v), n_under, vecs[v].exp_under);
            check($sformatf("v%0d_abort", v), n_abort, 0);
            check($sformatf("v%0d_ready", v), {31'd0, bus.o_Ready}, 32'd1);
            check($sformatf("v%0d_idle_miso", v), {30'd0, bus.o_MISO, bus.o_MISO_En}, 32'd0);
        end

        // Back-to-back frames in one CS window, second byte written mid-frame.
        clear_counts();
        write_byte(8'h01);
        run_frame(16, 3, 8'h03, got);
        check("b2b_bytes", {16'd0, got}, 32'h0103);
        check("b2b_done", n_done, 2);
        check("b2b_under", n_under, 0);

        // Partial frame abort, then an empty frame.
        clear_counts();
        write_byte(8'h03);
        run_frame(3, -1, 8'h00, got);
        check("abort_pulse", n_abort, 1);
        check("abort_done", n_done, 0);
        clear_counts();
        run_frame(8, -1, 8'h00, got);
        check("after_abort_byte", {24'd0, got[7:0]}, 32'h00);
        check("after_abort_under", n_under, 1);

        // Offer while full is ignored.
        clear_counts();
        write_byte(8'hAA);
        write_byte(8'h55);
        run_frame(8, -1, 8'h00, got);
        check("held_byte", {24'd0, got[7:0]}, 32'hAA);
        check("held_under", n_under, 0);
        clear_counts();
        run_frame(8, -1, 8'h00, got);
        check("offer_dropped_under", n_under, 1);
        check("offer_dropped_byte", {24'd0, got[7:0]}, 32'h00);

        // Write in the same cycle as the load: no bypass.
        clear_counts();
        bus.i_CS_n = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_Valid = 1'b1;
        bus.i_Data  = 8'h77;
        @(negedge clk);
        bus.i_Valid = 1'b0;
        check("same_cycle_ready", {31'd0, bus.o_Ready}, 32'd0);
        check("same_cycle_busy", {31'd0, bus.o_Busy}, 32'd1);
        repeat (4) @(negedge clk);
        clock_bits(16, -1, 8'h00, got);
        repeat (8) @(negedge clk);
        bus.i_CS_n = 1'b1;
        repeat (8) @(negedge clk);
        check("same_cycle_bytes", {16'd0, got}, 32'h0077);
        check("same_cycle_under", n_under, 1);
        check("same_cycle_done", n_done, 2);

        // Reset in the middle of a frame.
        clear_counts();
        write_byte(8'h5A);
        bus.i_CS_n = 1'b0;
        repeat (8) @(negedge clk);
        clock_bits(3, 1, 8'h66, got);
        check("pre_rst_ready", {31'd0, bus.o_Ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", {31'd0, bus.o_Ready}, 32'd1);
        check("midrst_outs", {26'd0, bus.o_MISO, bus.o_MISO_En, bus.o_Done,
                              bus.o_Underrun, bus.o_Abort, bus.o_Busy}, 32'd0);
        bus.i_CS_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_abort", n_abort, 0);
        check("midrst_idle", {31'd0, bus.o_Busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_state_tx.md
SPI_STATE_TX -- requirements
Module: spi_state_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the frame width in bits.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for i_SCK and i_CS_n.
REQ-003 Port i_Clk, input, 1 bit: system clock; all logic SHALL run on its rising edge.
REQ-004 Port i_Rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 Port i_Data, input, DATA_W bits: byte to transmit, typically the 8-bit FSM state code.
REQ-006 Port i_Valid, input, 1 bit: i_Data is offered this cycle.
REQ-007 Port o_Ready, output, 1 bit: the holding register is empty and can accept data.
REQ-008 Port i_SCK, input, 1 bit: SPI clock from the master, asynchronous, mode 0 (CPOL=0, CPHA=0).
REQ-009 Port i_CS_n, input, 1 bit: chip select from the master, asynchronous, active-low.
REQ-010 Port o_MISO, output, 1 bit: serial data, MSB first.
REQ-011 Port o_MISO_En, output, 1 bit: drive enable for an external tristate buffer.
REQ-012 Port o_Done, output, 1 bit: one-cycle pulse when a full frame has been sampled by the master.
REQ-013 Port o_Underrun, output, 1 bit: one-cycle pulse when a frame starts with the holding register empty.
REQ-014 Port o_Abort, output, 1 bit: one-cycle pulse when i_CS_n deasserts in the middle of a frame.
REQ-015 Port o_Busy, output, 1 bit: high while the state is SHIFT.

Function
REQ-016 i_SCK and i_CS_n SHALL each pass through SYNC_STAGES flops plus one history flop; edges SHALL be detected from the synchronized value and its history value.
REQ-017 i_Clk SHALL be at least 8x the SCK frequency; behaviour below that ratio is unspecified.
REQ-018 Holding register write: when i_Valid=1 and o_Ready=1, the block SHALL capture i_Data and set o_Ready=0 on the next cycle; i_Valid with o_Ready=0 SHALL be ignored.
REQ-019 The state machine SHALL have two states: IDLE (CS high) and SHIFT (CS low).
REQ-020 IDLE->SHIFT on a synchronized CS falling edge: the shift register SHALL be loaded from the holding register, the holding register freed (o_Ready=1 next cycle), and the bit counter cleared.
REQ-021 If the holding register is empty at a load, the shift register SHALL be loaded with 0 and o_Underrun SHALL pulse.
REQ-022 A load and an i_Valid write in the same cycle SHALL NOT bypass: the load sees the register empty (underrun), and the written byte stays held for the next load.
REQ-023 In SHIFT, o_MISO SHALL equal shift[DATA_W-1]; the first bit SHALL be valid no later than SYNC_STAGES+2 cycles after the CS_n pin falls.
REQ-024 On a synchronized SCK rising edge in SHIFT, the bit counter SHALL increment; at DATA_W-1 it SHALL wrap to 0 and o_Done SHALL pulse in the following cycle.
REQ-025 On a synchronized SCK falling edge in SHIFT, the shift register SHALL shift left, filling the LSB with 0, unless the counter is 0 and at least one frame has completed.
REQ-026 In that excepted case (counter 0 after a completed frame), the shift register SHALL reload from the holding register per REQ-020/021, giving back-to-back frames.
REQ-027 SHIFT->IDLE on a synchronized CS rising edge; if the counter is nonzero, o_Abort SHALL pulse and the partial byte SHALL be discarded, not requeued.
REQ-028 o_MISO_En SHALL be 1 only in SHIFT; o_MISO SHALL be 0 in IDLE.
REQ-029 SCK edges in IDLE SHALL be ignored.

Reset
REQ-030 With i_Rst=0 at a clock edge, the block SHALL go to IDLE and set o_Ready=1 and o_MISO=0, o_MISO_En=0, o_Done=0, o_Underrun=0, o_Abort=0, o_Busy=0.
REQ-031 Reset SHALL clear the holding register, shift register, counter and frame-completed flag; synchronizer flops SHALL reset to SCK=0 and CS_n=1.
REQ-032 Reset during SHIFT SHALL abandon the frame without an o_Abort pulse.

Verification
REQ-033 Write 0x02, then CS low and 8 SCK cycles -> MISO bits 0,0,0,0,0,0,1,0; one o_Done pulse; o_Ready=1.
REQ-034 CS low with nothing written -> o_Underrun pulse; MISO reads 0x00; o_Done still pulses after 8 bits.
REQ-035 Write 0x01, frame, write 0x03 during the frame, then 16 SCK cycles in a single CS window -> 0x01 then 0x03; two o_Done pulses; no underrun.
REQ-036 Write 0x03, CS rises after 3 SCK cycles -> o_Abort pulse; next frame with no write reads 0x00 with underrun.
REQ-037 i_Valid while o_Ready=0 (0xAA held, 0x55 offered) -> next frame reads 0xAA.
REQ-038 i_Rst=0 mid-frame -> all outputs at reset values next cycle; no o_Abort; o_Ready=1.
